channel: RTL and testbench

Synthesizable buffered link for the team's valid/data-acknowledge `Channel` and `DatalessChannel` protocol. It carries one N-bit data channel and one dataless synchronization channel, each through a small FIFO sized for full throughput. The FIFOs decouple combinational acknowledge paths between sender and receiver. It is placed between any two blocks that exchange `Channel`/`DatalessChannel` traffic, for example around merges, splits and stallers.

---
 rtl/channel_pkg.sv | 10 +
 rtl/channel_if.sv | 17 +
 rtl/channel_fifo.sv | 66 ++++++
 rtl/channel.sv | 72 +++++++
 tb/tb_channel.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/channel_pkg.sv
// Shared constants and helpers for the buffered channel link.
package channel_pkg;

  localparam int XFER_W = 32;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/channel_if.sv
// Valid/data-acknowledge channel interfaces shared by all blocks on the link.
interface Channel #(parameter int N = 8);
  logic [N-1:0] d;
  logic         v;
  logic         a;

  modport snd (output d, output v, input a);
  modport rcv (input d, input v, output a);
endinterface

interface DatalessChannel;
  logic v;
  logic a;

  modport snd (output v, input a);
  modport rcv (input v, output a);
endinterface

// File: rtl/channel_fifo.sv
// DEPTH-entry data FIFO; acknowledge depends only on occupancy, never on out_a.
module channel_fifo
  import channel_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_v,
  input  logic [N-1:0] in_d,
  output logic         in_a,
  output logic         out_v,
  output logic [N-1:0] out_d,
  input  logic         out_a
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [N-1:0]  mem [DEPTH];
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO refuses input even when a pop happens this cycle.
  assign in_a  = reset && (cnt_reg != CW'(DEPTH));
  assign out_v = (cnt_reg != '0);
  assign out_d = mem[rd_ptr_reg];
  assign push  = in_v && in_a;
  assign pop   = out_v && out_a;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    cnt_next    = cnt_reg;
    if (push) wr_ptr_next = ptr_inc(wr_ptr_reg);
    if (pop)  rd_ptr_next = ptr_inc(rd_ptr_reg);
    if (push && !pop)
      cnt_next = cnt_reg + CW'(1);
    else if (!push && pop)
      cnt_next = cnt_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      cnt_reg    <= cnt_next;
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_d;
  end

endmodule

// File: rtl/channel.sv
// Buffered link: one data channel through a FIFO plus one dataless token channel.
// CHANNEL_XFER_COUNT_EN enables the out-transfer counter; otherwise xfer_count is 0.
module channel
  import channel_pkg::*;
#(
  parameter int N     = 8,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  Channel.rcv               in,
  Channel.snd               out,
  DatalessChannel.rcv       sync_in,
  DatalessChannel.snd       sync_out,
  output logic [XFER_W-1:0] xfer_count
);

  localparam int CW = cnt_width(DEPTH);

  channel_fifo #(
    .N     (N),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .in_v  (in.v),
    .in_d  (in.d),
    .in_a  (in.a),
    .out_v (out.v),
    .out_d (out.d),
    .out_a (out.a)
  );

  // Sync path: tokens carry no payload, so a counter is the whole buffer.
  logic [CW-1:0] tok_reg, tok_next;
  logic          tok_push, tok_pop;

  assign sync_in.a  = reset && (tok_reg != CW'(DEPTH));
  assign sync_out.v = (tok_reg != '0);
  assign tok_push   = sync_in.v && sync_in.a;
  assign tok_pop    = sync_out.v && sync_out.a;

  always_comb begin
    tok_next = tok_reg;
    if (tok_push && !tok_pop)
      tok_next = tok_reg + CW'(1);
    else if (!tok_push && tok_pop)
      tok_next = tok_reg - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tok_reg <= '0;
    else        tok_reg <= tok_next;
  end

`ifdef CHANNEL_XFER_COUNT_EN
  logic              out_fire;
  logic [XFER_W-1:0] xfer_reg;

  assign out_fire = out.v && out.a;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        xfer_reg <= '0;
    else if (out_fire) xfer_reg <= xfer_reg + XFER_W'(1);
  end

  assign xfer_count = xfer_reg;
`else
  assign xfer_count = '0;
`endif

endmodule

// File: tb/tb_channel.sv
// Self-checking bench for channel: directed scenarios plus randomized traffic vs a queue model.
module tb_channel;
  localparam int N     = 4;
  localparam int DEPTH = 2;
`ifdef CHANNEL_XFER_COUNT_EN
  localparam logic [31:0] XF_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] XF_MASK = 32'h0;
`endif

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] xfer_count;

  Channel #(.N(N)) in_ch ();
  Channel #(.N(N)) out_ch ();
  DatalessChannel  sin_ch ();
  DatalessChannel  sout_ch ();

  channel #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in_ch),
    .out        (out_ch),
    .sync_in    (sin_ch),
    .sync_out   (sout_ch),
    .xfer_count (xfer_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of buffered items and a token count.
  logic [N-1:0] mq [$];
  int mtok  = 0;
  int mxfer = 0;
  bit pushed, popped, spushed, spopped;

  function automatic logic [31:0] xf(input int n);
    return 32'(n) & XF_MASK;
  endfunction

  // Called at a negedge: inputs are stable until the next posedge, so the
  // transfers decided here are the ones that happen at that posedge.
  task automatic advance();
    pushed  = reset && in_ch.v && (mq.size() != DEPTH);
    popped  = reset && out_ch.a && (mq.size() != 0);
    spushed = reset && sin_ch.v && (mtok != DEPTH);
    spopped = reset && sout_ch.a && (mtok != 0);
    if (popped) begin
      mq.delete(0);
      mxfer++;
    end
    if (pushed) mq.push_back(in_ch.d);
    mtok = mtok + int'(spushed) - int'(spopped);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    in_ch.v = 1'b0; in_ch.d = '0; out_ch.a = 1'b0; sin_ch.v = 1'b0; sout_ch.a = 1'b0;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (out_ch.v !== 1'b0) begin bad++; $display("FAIL reset_out_v c=%0d got=%b want=0", c, out_ch.v); end
      total++; if (in_ch.a !== 1'b0) begin bad++; $display("FAIL reset_in_a c=%0d got=%b want=0", c, in_ch.a); end
      total++; if (sout_ch.v !== 1'b0) begin bad++; $display("FAIL reset_sync_out_v c=%0d got=%b want=0", c, sout_ch.v); end
      total++; if (sin_ch.a !== 1'b0) begin bad++; $display("FAIL reset_sync_in_a c=%0d got=%b want=0", c, sin_ch.a); end
      total++; if (xfer_count !== 32'd0) begin bad++; $display("FAIL reset_xfer c=%0d got=%0d want=0", c, xfer_count); end
      advance();
    end
    reset = 1'b1;
    #1;
    total++; if (in_ch.a !== 1'b1) begin bad++; $display("FAIL release_in_a got=%b want=1", in_ch.a); end
    total++; if (sin_ch.a !== 1'b1) begin bad++; $display("FAIL release_sync_in_a got=%b want=1", sin_ch.a); end
    $display("reset: released, in.a=%b sync_in.a=%b", in_ch.a, sin_ch.a);
  endtask

  task automatic test_streaming();
    out_ch.a = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_ch.v = (c < 10);
      if (c < 10) in_ch.d = N'(c + 1);
      @(negedge clk);
      total++; if (in_ch.a !== 1'b1) begin bad++; $display("FAIL stream_in_a c=%0d got=%b want=1", c, in_ch.a); end
      total++; if (out_ch.v !== (c >= 1 && c <= 10)) begin bad++; $display("FAIL stream_out_v c=%0d got=%b want=%b", c, out_ch.v, (c >= 1 && c <= 10)); end
      if (c >= 1 && c <= 10) begin
        total++; if (out_ch.d !== N'(c)) begin bad++; $display("FAIL stream_out_d c=%0d got=%h want=%h", c, out_ch.d, N'(c)); end
        $display("stream: out item %h", out_ch.d);
      end
      advance();
    end
    in_ch.v = 1'b0;
    @(negedge clk);
    total++; if (xfer_count !== xf(10)) begin bad++; $display("FAIL stream_xfer got=%0d want=%0d", xfer_count, xf(10)); end
    advance();
  endtask

  task automatic test_backpressure();
    logic [N-1:0] got [$];
    logic [N-1:0] exp_d [3];
    exp_d[0] = 4'h5; exp_d[1] = 4'h6; exp_d[2] = 4'h7;
    out_ch.a = 1'b0;
    in_ch.v = 1'b1; in_ch.d = 4'h5;
    @(negedge clk);
    total++; if (in_ch.a !== 1'b1) begin bad++; $display("FAIL bp_accept5 got=%b want=1", in_ch.a); end
    advance();
    in_ch.d = 4'h6;
    @(negedge clk);
    total++; if (in_ch.a !== 1'b1) begin bad++; $display("FAIL bp_accept6 got=%b want=1", in_ch.a); end
    total++; if (out_ch.d !== 4'h5) begin bad++; $display("FAIL bp_head got=%h want=5", out_ch.d); end
    advance();
    in_ch.d = 4'h7;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++; if (in_ch.a !== 1'b0) begin bad++; $display("FAIL bp_full_in_a c=%0d got=%b want=0", c, in_ch.a); end
      advance();
    end
    out_ch.a = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) begin
        total++; if (in_ch.a !== 1'b0) begin bad++; $display("FAIL bp_full_with_pop got=%b want=0", in_ch.a); end
      end
      if (out_ch.v && out_ch.a) begin
        got.push_back(out_ch.d);
        $display("backpressure: out item %h", out_ch.d);
      end
      advance();
      if (pushed) in_ch.v = 1'b0;
    end
    total++; if (got.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      total++; if (got[i] !== exp_d[i]) begin bad++; $display("FAIL bp_order i=%0d got=%h want=%h", i, got[i], exp_d[i]); end
    end
  endtask

  task automatic test_sync();
    int sent = 0;
    int outs = 0;
    sout_ch.a = 1'b0;
    sin_ch.v  = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (sin_ch.a !== (c < 2)) begin bad++; $display("FAIL sync_in_a c=%0d got=%b want=%b", c, sin_ch.a, (c < 2)); end
      advance();
      if (spushed) sent++;
    end
    sout_ch.a = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      total++; if (sout_ch.v !== (mtok != 0)) begin bad++; $display("FAIL sync_out_v c=%0d got=%b want=%b", c, sout_ch.v, (mtok != 0)); end
      if (sout_ch.v && sout_ch.a) begin
        outs++;
        $display("sync: token out #%0d", outs);
      end
      advance();
      if (spushed) begin
        sent++;
        if (sent == 3) sin_ch.v = 1'b0;
      end
    end
    total++; if (outs != 3) begin bad++; $display("FAIL sync_out_count got=%0d want=3", outs); end
  endtask

  task automatic test_mid_reset();
    out_ch.a = 1'b0; sout_ch.a = 1'b0;
    in_ch.v = 1'b1; in_ch.d = 4'h9; sin_ch.v = 1'b1;
    @(negedge clk);
    advance();
    in_ch.d = 4'hA;
    @(negedge clk);
    total++; if (out_ch.v !== 1'b1) begin bad++; $display("FAIL midrst_prefill got=%b want=1", out_ch.v); end
    advance();
    in_ch.v = 1'b0; sin_ch.v = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    total++; if (out_ch.v !== 1'b0) begin bad++; $display("FAIL midrst_out_v got=%b want=0", out_ch.v); end
    total++; if (sout_ch.v !== 1'b0) begin bad++; $display("FAIL midrst_sync_out_v got=%b want=0", sout_ch.v); end
    total++; if (in_ch.a !== 1'b0) begin bad++; $display("FAIL midrst_in_a got=%b want=0", in_ch.a); end
    total++; if (xfer_count !== 32'd0) begin bad++; $display("FAIL midrst_xfer got=%0d want=0", xfer_count); end
    mq.delete(); mtok = 0; mxfer = 0;
    @(negedge clk);
    advance();
    reset = 1'b1;
    out_ch.a = 1'b1; sout_ch.a = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++; if (out_ch.v !== 1'b0) begin bad++; $display("FAIL midrst_stale_out c=%0d got=%b want=0", c, out_ch.v); end
      total++; if (sout_ch.v !== 1'b0) begin bad++; $display("FAIL midrst_stale_tok c=%0d got=%b want=0", c, sout_ch.v); end
      advance();
    end
    $display("mid-reset: buffers cleared");
  endtask

  task automatic test_random();
    int sent = 0;
    int recv = 0;
    int cycles = 0;
    int delay = $urandom_range(0, 5);
    int rdelay = $urandom_range(0, 5);
    in_ch.v = 1'b0; sin_ch.v = 1'b0;
    while (recv < 1000 && cycles < 20000) begin
      if (!in_ch.v && sent < 1000) begin
        if (delay == 0) begin
          in_ch.v = 1'b1;
          in_ch.d = N'($urandom);
        end else delay--;
      end
      out_ch.a = (rdelay == 0);
      if (rdelay > 0) rdelay--;
      sout_ch.a = 1'($urandom_range(0, 1));
      @(negedge clk);
      total++; if (in_ch.a !== (mq.size() != DEPTH)) begin bad++; $display("FAIL rand_in_a cyc=%0d got=%b want=%b", cycles, in_ch.a, (mq.size() != DEPTH)); end
      total++; if (out_ch.v !== (mq.size() != 0)) begin bad++; $display("FAIL rand_out_v cyc=%0d got=%b want=%b", cycles, out_ch.v, (mq.size() != 0)); end
      if (mq.size() != 0) begin
        total++; if (out_ch.d !== mq[0]) begin bad++; $display("FAIL rand_out_d cyc=%0d got=%h want=%h", cycles, out_ch.d, mq[0]); end
      end
      total++; if (sin_ch.a !== (mtok != DEPTH)) begin bad++; $display("FAIL rand_sync_in_a cyc=%0d got=%b want=%b", cycles, sin_ch.a, (mtok != DEPTH)); end
      total++; if (sout_ch.v !== (mtok != 0)) begin bad++; $display("FAIL rand_sync_out_v cyc=%0d got=%b want=%b", cycles, sout_ch.v, (mtok != 0)); end
      if (out_ch.v && out_ch.a) $display("random: item %0d out %h", recv, out_ch.d);
      advance();
      if (pushed) begin
        sent++;
        in_ch.v = 1'b0;
        delay = $urandom_range(0, 5);
      end
      if (popped) begin
        recv++;
        rdelay = $urandom_range(0, 5);
      end
      if (spushed) sin_ch.v = 1'b0;
      else if (!sin_ch.v) sin_ch.v = ($urandom_range(0, 2) == 0);
      cycles++;
    end
    total++; if (recv != 1000) begin bad++; $display("FAIL rand_timeout recv=%0d want=1000", recv); end
    in_ch.v = 1'b0; sin_ch.v = 1'b0;
    @(negedge clk);
    total++; if (xfer_count !== xf(1000)) begin bad++; $display("FAIL rand_xfer got=%0d want=%0d", xfer_count, xf(1000)); end
    advance();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_sync();
    test_mid_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
